// File: rtl/memory_port_arbiter_pkg.sv
// memory_port_arbiter_pkg
// Shared encodings for the block-RAM port arbiter: FSM state encoding,
// requester/owner encoding and the round-robin pick used on a tie.
// The datapath controller uses the same owner constants when it muxes
// its own memory requests.

package memory_port_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 16;
    localparam int DEFAULT_ADDRESS_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        RESPOND = 2'b10
    } arb_state_e;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_AUX = 1'b1;

    // A lone request wins outright; on a tie the requester that did not
    // win last time gets the port, so two busy requesters strictly alternate.
    function automatic logic pick_winner(input logic cpu_req,
                                         input logic aux_req,
                                         input logic last_owner);
        if (cpu_req && aux_req) begin
            return ~last_owner;
        end
        return aux_req ? OWNER_AUX : OWNER_CPU;
    endfunction

endpackage

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
// Shares the single synchronous-read block-RAM port between the CPU
// datapath and an auxiliary requester (display / I/O engine). The winning
// access is latched in IDLE, presented to the RAM for exactly one cycle
// (ACCESS), then acknowledged for one cycle (RESPOND) while the RAM's
// registered read data is on the shared bus.
//
// Ports
//   clock, reset                 system clock, async active-high reset
//   cpu_request/write_enable/address/write_data   CPU access request
//   cpu_acknowledge, cpu_read_data                CPU completion + data
//   aux_request/write_enable/address/write_data   auxiliary access request
//   aux_acknowledge, aux_read_data                aux completion + data
//   memory_address/write_enable/write_data        registered RAM port
//   memory_read_data                              RAM output (1-cycle latency)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; latches the winner's access on grant
// ACCESS  | latched address/data on the RAM port, write strobe if a write
// RESPOND | owner's acknowledge high, read data valid on the shared bus

module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     cpu_request,
    input  logic                     cpu_write_enable,
    input  logic [ADDRESS_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0]    cpu_write_data,
    output logic                     cpu_acknowledge,
    output logic [DATA_WIDTH-1:0]    cpu_read_data,

    input  logic                     aux_request,
    input  logic                     aux_write_enable,
    input  logic [ADDRESS_WIDTH-1:0] aux_address,
    input  logic [DATA_WIDTH-1:0]    aux_write_data,
    output logic                     aux_acknowledge,
    output logic [DATA_WIDTH-1:0]    aux_read_data,

    output logic [ADDRESS_WIDTH-1:0] memory_address,
    output logic                     memory_write_enable,
    output logic [DATA_WIDTH-1:0]    memory_write_data,
    input  logic [DATA_WIDTH-1:0]    memory_read_data
);

    arb_state_e               state_q, state_d;
    logic                     owner_q, owner_d;
    logic                     last_owner_q, last_owner_d;
    logic                     write_enable_q, write_enable_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
    logic                     cpu_ack_q, cpu_ack_d;
    logic                     aux_ack_q, aux_ack_d;

    logic                     any_request;
    logic                     winner;

    assign any_request = cpu_request | aux_request;
    assign winner      = pick_winner(cpu_request, aux_request, last_owner_q);

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_owner_d   = last_owner_q;
        address_d      = address_q;
        write_data_d   = write_data_q;
        // Write strobe and acknowledges are single-cycle; they are only
        // raised on the transition into the state that owns them.
        write_enable_d = 1'b0;
        cpu_ack_d      = 1'b0;
        aux_ack_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_request) begin
                    owner_d      = winner;
                    last_owner_d = winner;
                    if (winner == OWNER_AUX) begin
                        address_d      = aux_address;
                        write_data_d   = aux_write_data;
                        write_enable_d = aux_write_enable;
                    end else begin
                        address_d      = cpu_address;
                        write_data_d   = cpu_write_data;
                        write_enable_d = cpu_write_enable;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cpu_ack_d = (owner_q == OWNER_CPU);
                aux_ack_d = (owner_q == OWNER_AUX);
                state_d   = RESPOND;
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            owner_q        <= OWNER_CPU;
            last_owner_q   <= OWNER_AUX;
            write_enable_q <= 1'b0;
            address_q      <= '0;
            write_data_q   <= '0;
            cpu_ack_q      <= 1'b0;
            aux_ack_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_owner_q   <= last_owner_d;
            write_enable_q <= write_enable_d;
            address_q      <= address_d;
            write_data_q   <= write_data_d;
            cpu_ack_q      <= cpu_ack_d;
            aux_ack_q      <= aux_ack_d;
        end
    end

    assign memory_address      = address_q;
    assign memory_write_data   = write_data_q;
    assign memory_write_enable = write_enable_q;

    assign cpu_acknowledge = cpu_ack_q;
    assign aux_acknowledge = aux_ack_q;

    // Both requesters see the RAM output; only the acknowledged one may use it.
    assign cpu_read_data = memory_read_data;
    assign aux_read_data = memory_read_data;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Testbench for memory_port_arbiter: behavioural RAM, directed scenarios and
// a randomized two-requester run checked against a transaction-level model.

module tb_memory_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;

    logic          cpu_request = 1'b0;
    logic          cpu_write_enable = 1'b0;
    logic [AW-1:0] cpu_address = '0;
    logic [DW-1:0] cpu_write_data = '0;
    logic          cpu_acknowledge;
    logic [DW-1:0] cpu_read_data;

    logic          aux_request = 1'b0;
    logic          aux_write_enable = 1'b0;
    logic [AW-1:0] aux_address = '0;
    logic [DW-1:0] aux_write_data = '0;
    logic          aux_acknowledge;
    logic [DW-1:0] aux_read_data;

    logic [AW-1:0] memory_address;
    logic          memory_write_enable;
    logic [DW-1:0] memory_write_data;
    logic [DW-1:0] memory_read_data;

    logic [DW-1:0] ram    [0:65535];
    logic [DW-1:0] shadow [0:65535];
    logic          tb_we = 1'b0;
    logic          tb_clear = 1'b0;
    logic [AW-1:0] tb_addr = '0;
    logic [DW-1:0] tb_data = '0;

    int checks = 0;
    int errors = 0;

    memory_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clock               (clock),
        .reset               (reset),
        .cpu_request         (cpu_request),
        .cpu_write_enable    (cpu_write_enable),
        .cpu_address         (cpu_address),
        .cpu_write_data      (cpu_write_data),
        .cpu_acknowledge     (cpu_acknowledge),
        .cpu_read_data       (cpu_read_data),
        .aux_request         (aux_request),
        .aux_write_enable    (aux_write_enable),
        .aux_address         (aux_address),
        .aux_write_data      (aux_write_data),
        .aux_acknowledge     (aux_acknowledge),
        .aux_read_data       (aux_read_data),
        .memory_address      (memory_address),
        .memory_write_enable (memory_write_enable),
        .memory_write_data   (memory_write_data),
        .memory_read_data    (memory_read_data)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM: read-before-write, one cycle latency.
    always @(posedge clock) begin
        memory_read_data <= ram[memory_address];
        if (tb_clear) begin
            for (int i = 0; i < 65536; i++) ram[i] = 16'(i ^ 32'h5a5a);
        end else if (tb_we) begin
            ram[tb_addr] = tb_data;
        end else if (memory_write_enable) begin
            ram[memory_address] = memory_write_data;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        cpu_request = 1'b0;
        aux_request = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tb_we = 1'b1;
        tb_addr = a;
        tb_data = d;
        @(posedge clock);
        @(negedge clock);
        tb_we = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int e = 0; e < 2; e++) begin
            checks++; if (cpu_acknowledge !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack got %b want 0", cpu_acknowledge); end
            checks++; if (aux_acknowledge !== 1'b0) begin errors++; $display("FAIL reset_aux_ack got %b want 0", aux_acknowledge); end
            checks++; if (memory_write_enable !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", memory_write_enable); end
            checks++; if (memory_address !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr got %h want 0000", memory_address); end
            checks++; if (memory_write_data !== 16'h0000) begin errors++; $display("FAIL reset_mem_wdata got %h want 0000", memory_write_data); end
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic test_cpu_read();
        preload(16'h0010, 16'hBEEF);
        cpu_request = 1'b1; cpu_write_enable = 1'b0; cpu_address = 16'h0010; cpu_write_data = 16'h0000;
        for (int e = 0; e < 3; e++) begin
            @(posedge clock);
            @(negedge clock);
            checks++; if (cpu_acknowledge !== (e == 1)) begin errors++; $display("FAIL cpu_read_ack e=%0d got %b want %b", e, cpu_acknowledge, (e == 1)); end
            checks++; if (aux_acknowledge !== 1'b0) begin errors++; $display("FAIL cpu_read_aux_ack e=%0d got %b want 0", e, aux_acknowledge); end
            checks++; if (memory_write_enable !== 1'b0) begin errors++; $display("FAIL cpu_read_we e=%0d got %b want 0", e, memory_write_enable); end
            if (e == 0) begin
                checks++; if (memory_address !== 16'h0010) begin errors++; $display("FAIL cpu_read_addr got %h want 0010", memory_address); end
            end
            if (e == 1) begin
                checks++; if (cpu_read_data !== 16'hBEEF) begin errors++; $display("FAIL cpu_read_data got %h want beef", cpu_read_data); end
                cpu_request = 1'b0;
            end
        end
    endtask

    task automatic test_aux_write();
        preload(16'h0020, 16'h0000);
        aux_request = 1'b1; aux_write_enable = 1'b1; aux_address = 16'h0020; aux_write_data = 16'h1234;
        for (int e = 0; e < 5; e++) begin
            @(posedge clock);
            @(negedge clock);
            checks++; if (memory_write_enable !== (e == 0)) begin errors++; $display("FAIL aux_write_we e=%0d got %b want %b", e, memory_write_enable, (e == 0)); end
            checks++; if (aux_acknowledge !== (e == 1)) begin errors++; $display("FAIL aux_write_aux_ack e=%0d got %b want %b", e, aux_acknowledge, (e == 1)); end
            checks++; if (cpu_acknowledge !== (e == 4)) begin errors++; $display("FAIL aux_write_cpu_ack e=%0d got %b want %b", e, cpu_acknowledge, (e == 4)); end
            case (e)
                0: begin
                    checks++; if (memory_address !== 16'h0020) begin errors++; $display("FAIL aux_write_addr got %h want 0020", memory_address); end
                    checks++; if (memory_write_data !== 16'h1234) begin errors++; $display("FAIL aux_write_wdata got %h want 1234", memory_write_data); end
                end
                1: begin
                    aux_request = 1'b0; aux_write_enable = 1'b0;
                    cpu_request = 1'b1; cpu_write_enable = 1'b0; cpu_address = 16'h0020;
                end
                4: begin
                    checks++; if (cpu_read_data !== 16'h1234) begin errors++; $display("FAIL aux_write_readback got %h want 1234", cpu_read_data); end
                    cpu_request = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_tie();
        apply_reset();
        preload(16'h0030, 16'hAAAA);
        preload(16'h0031, 16'h5555);
        cpu_request = 1'b1; cpu_write_enable = 1'b0; cpu_address = 16'h0030;
        aux_request = 1'b1; aux_write_enable = 1'b0; aux_address = 16'h0031;
        for (int e = 0; e < 11; e++) begin
            @(posedge clock);
            @(negedge clock);
            checks++; if (cpu_acknowledge !== (e == 1 || e == 7)) begin errors++; $display("FAIL tie_cpu_ack e=%0d got %b want %b", e, cpu_acknowledge, (e == 1 || e == 7)); end
            checks++; if (aux_acknowledge !== (e == 4 || e == 10)) begin errors++; $display("FAIL tie_aux_ack e=%0d got %b want %b", e, aux_acknowledge, (e == 4 || e == 10)); end
            if (e == 1 || e == 7) begin
                checks++; if (cpu_read_data !== 16'hAAAA) begin errors++; $display("FAIL tie_cpu_data e=%0d got %h want aaaa", e, cpu_read_data); end
            end
            if (e == 4 || e == 10) begin
                checks++; if (aux_read_data !== 16'h5555) begin errors++; $display("FAIL tie_aux_data e=%0d got %h want 5555", e, aux_read_data); end
            end
            if (e == 7) cpu_request = 1'b0;
            if (e == 10) aux_request = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [3];
        int k;
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        preload(16'h0001, vals[0]);
        preload(16'h0002, vals[1]);
        preload(16'h0003, vals[2]);
        k = 0;
        cpu_request = 1'b1; cpu_write_enable = 1'b0; cpu_address = 16'h0001;
        for (int e = 0; e < 10; e++) begin
            @(posedge clock);
            @(negedge clock);
            checks++; if (cpu_acknowledge !== (e == 1 || e == 4 || e == 7)) begin errors++; $display("FAIL b2b_cpu_ack e=%0d got %b want %b", e, cpu_acknowledge, (e == 1 || e == 4 || e == 7)); end
            checks++; if (aux_acknowledge !== 1'b0) begin errors++; $display("FAIL b2b_aux_ack e=%0d got %b want 0", e, aux_acknowledge); end
            if (e == 1 || e == 4 || e == 7) begin
                checks++; if (cpu_read_data !== vals[k]) begin errors++; $display("FAIL b2b_data e=%0d got %h want %h", e, cpu_read_data, vals[k]); end
                k++;
                if (k < 3) cpu_address = 16'(k + 1);
                else cpu_request = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_access();
        preload(16'h0040, 16'h0BAD);
        preload(16'h0041, 16'h7E57);
        cpu_request = 1'b1; cpu_write_enable = 1'b1; cpu_address = 16'h0040; cpu_write_data = 16'hCAFE;
        @(posedge clock);
        @(negedge clock);
        checks++; if (memory_write_enable !== 1'b1) begin errors++; $display("FAIL midrst_we_before got %b want 1", memory_write_enable); end
        #1 reset = 1'b1;
        #1;
        checks++; if (memory_write_enable !== 1'b0) begin errors++; $display("FAIL midrst_we_drop got %b want 0", memory_write_enable); end
        checks++; if (memory_address !== 16'h0000) begin errors++; $display("FAIL midrst_addr got %h want 0000", memory_address); end
        checks++; if (memory_write_data !== 16'h0000) begin errors++; $display("FAIL midrst_wdata got %h want 0000", memory_write_data); end
        cpu_request = 1'b0; cpu_write_enable = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++; if (cpu_acknowledge !== 1'b0) begin errors++; $display("FAIL midrst_ack_in_reset got %b want 0", cpu_acknowledge); end
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++; if (cpu_acknowledge !== 1'b0) begin errors++; $display("FAIL midrst_no_ack got %b want 0", cpu_acknowledge); end
        // Tie right after reset: CPU must win again, and the abandoned write must not have landed.
        cpu_request = 1'b1; cpu_write_enable = 1'b0; cpu_address = 16'h0040;
        aux_request = 1'b1; aux_write_enable = 1'b0; aux_address = 16'h0041;
        for (int e = 0; e < 5; e++) begin
            @(posedge clock);
            @(negedge clock);
            checks++; if (cpu_acknowledge !== (e == 1)) begin errors++; $display("FAIL midrst_cpu_ack e=%0d got %b want %b", e, cpu_acknowledge, (e == 1)); end
            checks++; if (aux_acknowledge !== (e == 4)) begin errors++; $display("FAIL midrst_aux_ack e=%0d got %b want %b", e, aux_acknowledge, (e == 4)); end
            if (e == 1) begin
                checks++; if (cpu_read_data !== 16'h0BAD) begin errors++; $display("FAIL midrst_nowrite got %h want 0bad", cpu_read_data); end
                cpu_request = 1'b0;
            end
            if (e == 4) begin
                checks++; if (aux_read_data !== 16'h7E57) begin errors++; $display("FAIL midrst_aux_data got %h want 7e57", aux_read_data); end
                aux_request = 1'b0;
            end
        end
    endtask

    // Transaction model: the port is free for a new grant 3 edges after the
    // previous grant; a grant at edge g strobes the RAM after edge g and
    // acknowledges after edge g+1. Ties go to whoever did not win last.
    task automatic test_random();
        int            free_at = 0;
        int            grant_edge = -10;
        logic          g_is_aux = 1'b0;
        logic          g_we = 1'b0;
        logic [AW-1:0] g_addr = '0;
        logic [DW-1:0] g_data = '0;
        logic          last_is_aux = 1'b1;
        logic          win_aux;
        logic          exp_we, exp_cack, exp_aack;
        logic [DW-1:0] got;
        apply_reset();
        tb_clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        tb_clear = 1'b0;
        for (int i = 0; i < 65536; i++) shadow[i] = 16'(i ^ 32'h5a5a);
        for (int e = 0; e < 1500; e++) begin
            @(posedge clock);
            if (e >= free_at && (cpu_request || aux_request)) begin
                if (cpu_request && aux_request) win_aux = ~last_is_aux;
                else win_aux = aux_request;
                g_is_aux = win_aux;
                g_we   = win_aux ? aux_write_enable : cpu_write_enable;
                g_addr = win_aux ? aux_address : cpu_address;
                g_data = win_aux ? aux_write_data : cpu_write_data;
                last_is_aux = win_aux;
                grant_edge = e;
                free_at = e + 3;
            end
            @(negedge clock);
            exp_we   = (e == grant_edge) && g_we;
            exp_cack = (e == grant_edge + 1) && !g_is_aux;
            exp_aack = (e == grant_edge + 1) && g_is_aux;
            checks++; if (cpu_acknowledge !== exp_cack) begin errors++; $display("FAIL rnd_cpu_ack e=%0d got %b want %b", e, cpu_acknowledge, exp_cack); end
            checks++; if (aux_acknowledge !== exp_aack) begin errors++; $display("FAIL rnd_aux_ack e=%0d got %b want %b", e, aux_acknowledge, exp_aack); end
            checks++; if (memory_write_enable !== exp_we) begin errors++; $display("FAIL rnd_we e=%0d got %b want %b", e, memory_write_enable, exp_we); end
            if (e == grant_edge || e == grant_edge + 1) begin
                checks++; if (memory_address !== g_addr) begin errors++; $display("FAIL rnd_addr e=%0d got %h want %h", e, memory_address, g_addr); end
            end
            if (e == grant_edge && g_we) begin
                checks++; if (memory_write_data !== g_data) begin errors++; $display("FAIL rnd_wdata e=%0d got %h want %h", e, memory_write_data, g_data); end
            end
            if (e == grant_edge + 1) begin
                if (g_we) begin
                    shadow[g_addr] = g_data;
                end else begin
                    got = g_is_aux ? aux_read_data : cpu_read_data;
                    checks++; if (got !== shadow[g_addr]) begin errors++; $display("FAIL rnd_rdata e=%0d addr %h got %h want %h", e, g_addr, got, shadow[g_addr]); end
                end
                if (g_is_aux) aux_request = 1'b0;
                else cpu_request = 1'b0;
            end
            if (!cpu_request && $urandom_range(0, 2) != 0) begin
                cpu_request = 1'b1;
                cpu_write_enable = 1'($urandom_range(0, 1));
                cpu_address = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
                cpu_write_data = 16'($urandom);
            end
            if (!aux_request && $urandom_range(0, 2) != 0) begin
                aux_request = 1'b1;
                aux_write_enable = 1'($urandom_range(0, 1));
                aux_address = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
                aux_write_data = 16'($urandom);
            end
        end
        cpu_request = 1'b0;
        aux_request = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_aux_write();
        test_tie();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares the single synchronous-read block-RAM port between the CPU datapath (fetch, LOAD, STOR) and an auxiliary requester such as the display or I/O engine. Each requester uses a request/acknowledge handshake. The arbiter registers the winning access, drives the RAM port for exactly one cycle, then acknowledges. It sits between the controller/datapath memory-address mux and the RAM, replacing the CPU's direct connection.

## Interface
- DATA_WIDTH, 16, width of memory words and data buses
- ADDRESS_WIDTH, 16, width of memory addresses
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and all register resets
- cpu_request  in  1  CPU access request, held until acknowledged
- cpu_write_enable  in  1  1 = write, 0 = read
- cpu_address  in  ADDRESS_WIDTH  CPU access address
- cpu_write_data  in  DATA_WIDTH  CPU store data
- cpu_acknowledge  out  1  one-cycle pulse: CPU access complete
- cpu_read_data  out  DATA_WIDTH  equals memory_read_data; valid only while cpu_acknowledge=1
- aux_request, aux_write_enable, aux_address, aux_write_data  in  same widths as the CPU inputs  auxiliary requester
- aux_acknowledge  out  1  one-cycle pulse: auxiliary access complete
- aux_read_data  out  DATA_WIDTH  equals memory_read_data; valid only while aux_acknowledge=1
- memory_address  out  ADDRESS_WIDTH  registered RAM address
- memory_write_enable  out  1  RAM write strobe
- memory_write_data  out  DATA_WIDTH  registered RAM write data
- memory_read_data  in  DATA_WIDTH  RAM output, valid one cycle after the address is presented

## Operation
- States: IDLE, ACCESS, RESPOND. Registers: owner (CPU/AUX), last_owner, latched write_enable, address, write_data.
- IDLE: if no request, stay.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester that is not last_owner (round-robin).
  - On grant: latch owner, address, write data and write_enable from the winner; set last_owner = winner; go to ACCESS.
- ACCESS: memory_address and memory_write_data come from the latch registers. memory_write_enable = latched write_enable. Go to RESPOND.
- RESPOND: assert the owner's acknowledge; read data is valid on the shared bus. memory_write_enable = 0. Go to IDLE.
- Acknowledge is decoded from state plus owner (Moore). The non-owner's acknowledge stays 0.
- Requester rule: on the clock edge that samples acknowledge=1, the requester drops its request or presents a new access. The arbiter does not check this rule; a request still high in IDLE is treated as a new access.
- Request inputs are ignored outside IDLE. The requester must hold its address and data stable from request until acknowledge, although only the IDLE sample is used.
- Reset values:
  - state = IDLE, owner = CPU, last_owner = AUX (CPU wins the first tie).
  - memory_address = 0, memory_write_data = 0, memory_write_enable = 0.
  - Both acknowledges = 0.
- Reset mid-operation: because reset is asynchronous, memory_write_enable and the acknowledges fall to 0 immediately. An in-flight access is abandoned with no acknowledge, and the requester must re-request.
- Widths: all address and data paths pass through unchanged. There is no arithmetic and no truncation.

## Timing
- A request sampled high in IDLE at edge k gives ACCESS in cycle k+1 and acknowledge in cycle k+2. Latency is 2 cycles from the grant edge.
- Peak throughput is one access per 3 cycles. With both requesters continuously busy, grants strictly alternate.
- A write commits to the RAM at the edge ending ACCESS.
- Read data is valid during RESPOND (the RAM's 1-cycle latency).
- memory_address holds its last value in IDLE and RESPOND.

## Structure
- Shared include file: state encodings (IDLE=2'b00, ACCESS=2'b01, RESPOND=2'b10), owner encodings (OWNER_CPU=1'b0, OWNER_AUX=1'b1). The controller uses the same owner constants.
- A single flat module. The round-robin pick is two gates and does not justify a sub-module.

## Test plan
- CPU read alone: RAM[0x0010]=0xBEEF, cpu_request high at edge 0 with address 0x0010 → cpu_acknowledge=1 in cycle 2 with cpu_read_data=0xBEEF; aux_acknowledge stays 0.
- AUX write: aux writes 0x1234 to 0x0020 → memory_write_enable high only in cycle 1, then aux_acknowledge in cycle 2; a following CPU read of 0x0020 returns 0x1234.
- Tie after reset: both request at edge 0 → CPU is acknowledged in cycle 2 and AUX in cycle 5. With both held, the next grant goes to CPU (alternation continues).
- Back-to-back same requester: CPU keeps requesting new addresses 0x0001, 0x0002, 0x0003 → acknowledges in cycles 2, 5, 8, each with the correct data.
- Reset during ACCESS of a write: assert reset mid-cycle 1 → memory_write_enable drops immediately, no acknowledge, state IDLE, all outputs at their reset values.
